// File: rtl/btensor_psum_accum.sv
// Partial-sum accumulation stage: element-wise signed K-tile accumulation.
// Optional saturating adders: define BTC_PSUM_SAT_EN.
module btensor_psum_accum #(
    parameter int NUM_OCT = 4,
    parameter int LANES   = 4,
    parameter int LANE_W  = 32,
    parameter int MAX_K   = 64,
    localparam int DW     = NUM_OCT * LANES * LANE_W,
    localparam int CW     = $clog2(MAX_K + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic [NUM_OCT-1:0] oct_mask,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [DW-1:0]      in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      beat_cnt,
    output logic               sat_flag,
    output logic               proto_err,
    output logic               kovf_err
);

    localparam int EL = NUM_OCT * LANES;
    localparam logic [CW-1:0] KMAX = CW'(MAX_K);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t        state;
    logic [DW-1:0] acc;
    logic [DW-1:0] masked;
    logic [DW-1:0] nxt;
    logic          take;
    logic          start;

    assign in_ready = !out_valid || out_ready;
    assign take     = in_valid && in_ready;
    assign start    = in_first || (state == IDLE);

    always_comb begin
        masked = in_data;
        for (int o = 0; o < NUM_OCT; o++) begin
            for (int e = 0; e < LANES; e++) begin
                if (!oct_mask[o]) begin
                    masked[(o*LANES+e)*LANE_W +: LANE_W] = '0;
                end
            end
        end
    end

`ifdef BTC_PSUM_SAT_EN
    logic [EL-1:0] clamp;
    logic [LANE_W:0] s;

    always_comb begin
        nxt   = masked;
        clamp = '0;
        s     = '0;
        if (!start) begin
            for (int i = 0; i < EL; i++) begin
                s = {acc[i*LANE_W+LANE_W-1], acc[i*LANE_W +: LANE_W]}
                  + {masked[i*LANE_W+LANE_W-1], masked[i*LANE_W +: LANE_W]};
                if (s[LANE_W] != s[LANE_W-1]) begin
                    clamp[i] = 1'b1;
                    nxt[i*LANE_W +: LANE_W] = s[LANE_W]
                        ? {1'b1, {(LANE_W-1){1'b0}}}
                        : {1'b0, {(LANE_W-1){1'b1}}};
                end else begin
                    nxt[i*LANE_W +: LANE_W] = s[LANE_W-1:0];
                end
            end
        end
    end
`else
    always_comb begin
        nxt = masked;
        if (!start) begin
            for (int i = 0; i < EL; i++) begin
                nxt[i*LANE_W +: LANE_W] = acc[i*LANE_W +: LANE_W]
                                        + masked[i*LANE_W +: LANE_W];
            end
        end
    end

    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
            kovf_err  <= 1'b0;
`ifdef BTC_PSUM_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // clr wins over a beat accepted in the same cycle
            if (clr) begin
                state     <= IDLE;
                acc       <= '0;
                beat_cnt  <= '0;
                proto_err <= 1'b0;
                kovf_err  <= 1'b0;
`ifdef BTC_PSUM_SAT_EN
                sat_flag  <= 1'b0;
`endif
            end else if (take) begin
                if (in_first && state == ACCUM) begin
                    proto_err <= 1'b1;
                end
                if (!in_last && !start && beat_cnt == KMAX) begin
                    kovf_err <= 1'b1;
                end
`ifdef BTC_PSUM_SAT_EN
                if (|clamp) begin
                    sat_flag <= 1'b1;
                end
`endif
                if (in_last) begin
                    out_data  <= nxt;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    beat_cnt  <= '0;
                    state     <= IDLE;
                end else begin
                    acc   <= nxt;
                    state <= ACCUM;
                    if (start) begin
                        beat_cnt <= CW'(1);
                    end else if (beat_cnt != KMAX) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule
